generic_bus_arbiter: RTL and testbench

//  Parametrised N-channel arbiter that multiplexes NUM_CH generic-bus requestors onto one

---
 rtl/generic_bus_arbiter_pkg.sv | 22 ++
 rtl/generic_bus_arbiter_if.sv | 21 ++
 rtl/generic_bus_arbiter_rr_pick.sv | 27 ++
 rtl/generic_bus_arbiter.sv | 93 +++++++++
 tb/tb_generic_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/generic_bus_arbiter_pkg.sv
// Shared types and helpers for the generic-bus arbiter.
package generic_bus_pkg;

  // Arbiter FSM: waiting for a request, or forwarding one channel to the slave.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Selection policies.
  localparam int ARB_RR = 0;  // round-robin
  localparam int ARB_FP = 1;  // fixed priority, channel 0 highest

  // Modular add for channel indices; NUM_CH need not be a power of two.
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/generic_bus_arbiter_if.sv
// Generic bus bundle. NCH channels share one rdata; addr/wdata/byte_en are
// packed per channel (channel i at [i*W +: W]). "master" drives requests,
// "slave" answers with rdata/busy.
interface generic_bus_arbiter_if #(
  parameter int NCH    = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [NCH*ADDR_W-1:0] addr;
  logic [NCH*DATA_W-1:0] wdata;
  logic [NCH*BE_W-1:0]   byte_en;
  logic [NCH-1:0]        ren;
  logic [NCH-1:0]        wen;
  logic [DATA_W-1:0]     rdata;
  logic [NCH-1:0]        busy;

  modport master (output addr, wdata, byte_en, ren, wen, input rdata, busy);
  modport slave  (input addr, wdata, byte_en, ren, wen, output rdata, busy);
endinterface

// File: rtl/generic_bus_arbiter_rr_pick.sv
// Combinational winner selection: round-robin from rr_ptr, or lowest index.
module rr_pick
  import generic_bus_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_vec_i,
  input  logic [IDX_W-1:0]  rr_ptr_i,
  input  logic              mode_i,    // 1 = fixed priority
  output logic [IDX_W-1:0]  winner_o,
  output logic              valid_o
);

  // Scan from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    int idx;
    idx      = 0;
    winner_o = '0;
    valid_o  = |req_vec_i;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = mode_i ? k : wrap_add(int'(rr_ptr_i), k, NUM_CH);
      if (req_vec_i[idx]) winner_o = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/generic_bus_arbiter.sv
// N-channel generic-bus arbiter: one requestor at a time is forwarded to a
// single slave port; a grant lasts until completion or until the requestor
// withdraws its request.
module generic_bus_arbiter
  import generic_bus_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = ARB_RR
) (
  input logic CLK,
  input logic nRST,
  generic_bus_arbiter_if.slave  m_bus,  // requestor side, NUM_CH channels
  generic_bus_arbiter_if.master s_bus   // slave side, single channel
);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int BE_W  = DATA_W / 8;

  arb_state_t        state_q;
  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  rr_ptr_q;

  logic [NUM_CH-1:0] req_vec;
  logic [IDX_W-1:0]  winner;
  logic              winner_vld;
  logic              gnt_active;
  logic              g_ren;
  logic              g_wen;
  logic              g_req;
  logic [IDX_W-1:0]  next_ptr;

  assign req_vec = m_bus.ren | m_bus.wen;

  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req_vec_i (req_vec),
    .rr_ptr_i  (rr_ptr_q),
    .mode_i    (ARB_MODE == ARB_FP),
    .winner_o  (winner),
    .valid_o   (winner_vld)
  );

  assign gnt_active = (state_q == GRANT);
  assign g_ren      = m_bus.ren[grant_q];
  assign g_wen      = m_bus.wen[grant_q];
  assign g_req      = g_ren | g_wen;
  assign next_ptr   = IDX_W'(wrap_add(int'(grant_q), 1, NUM_CH));

  // Slave request follows the granted channel directly so an abort drops it the same cycle.
  assign s_bus.ren[0]  = gnt_active & g_ren;
  assign s_bus.wen[0]  = gnt_active & g_wen;
  assign s_bus.addr    = gnt_active ? m_bus.addr[grant_q*ADDR_W +: ADDR_W] : '0;
  assign s_bus.wdata   = gnt_active ? m_bus.wdata[grant_q*DATA_W +: DATA_W] : '0;
  assign s_bus.byte_en = gnt_active ? m_bus.byte_en[grant_q*BE_W +: BE_W] : '0;

  // Read data is broadcast; only the channel whose busy is low may use it.
  assign m_bus.rdata = s_bus.rdata;

  // Per-channel busy: only the granted, still-requesting channel sees slave busy.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_busy
      assign m_bus.busy[gi] = !(gnt_active && g_req && (grant_q == IDX_W'(gi)))
                              | s_bus.busy[0];
    end
  endgenerate

  // Arbitration FSM: pick in IDLE, release on completion or abort.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (winner_vld) begin
            grant_q <= winner;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!g_req || !s_bus.busy[0]) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_ptr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Scoreboard bench: two 4-channel arbiters (round-robin and fixed priority),
// each with a behavioural slave. Stimulus pushes expected completions; monitors
// pop and compare whenever a busy bit goes low.
module tb_generic_bus_arbiter;
  import generic_bus_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  generic_bus_arbiter_if #(.NCH(4), .ADDR_W(32), .DATA_W(32)) m_rr ();
  generic_bus_arbiter_if #(.NCH(1), .ADDR_W(32), .DATA_W(32)) s_rr ();
  generic_bus_arbiter_if #(.NCH(4), .ADDR_W(32), .DATA_W(32)) m_fp ();
  generic_bus_arbiter_if #(.NCH(1), .ADDR_W(32), .DATA_W(32)) s_fp ();

  generic_bus_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(ARB_RR)) dut_rr (
    .CLK(CLK), .nRST(nRST), .m_bus(m_rr), .s_bus(s_rr)
  );
  generic_bus_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(ARB_FP)) dut_fp (
    .CLK(CLK), .nRST(nRST), .m_bus(m_fp), .s_bus(s_fp)
  );

  // Slave for the RR arbiter: rr_wait busy cycles per transaction, rdata from a variable.
  int          rr_wait = 0;
  int          rr_cnt  = 0;
  logic [31:0] rr_rdata;
  assign s_rr.busy[0] = (s_rr.ren[0] | s_rr.wen[0]) && (rr_cnt < rr_wait);
  assign s_rr.rdata   = rr_rdata;
  always @(posedge CLK) begin
    if ((s_rr.ren[0] | s_rr.wen[0]) && s_rr.busy[0]) rr_cnt <= rr_cnt + 1;
    else rr_cnt <= 0;
  end

  // Slave for the FP arbiter: zero-wait, rdata derived from address.
  assign s_fp.busy[0] = 1'b0;
  assign s_fp.rdata   = {16'hF00D, s_fp.addr[15:0]};

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;  // rdata for reads, wdata for writes
    logic [3:0]  be;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fp[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int d, input int ch, input logic [31:0] addr, input logic wr,
                      input logic [31:0] data, input logic [3:0] be);
    exp_t e;
    e.ch = ch; e.addr = addr; e.wr = wr; e.data = data; e.be = be;
    if (d == 0) q_rr.push_back(e);
    else q_fp.push_back(e);
  endtask

  // Monitor for the RR arbiter.
  always @(negedge CLK) begin : mon_rr
    exp_t e;
    if (nRST === 1'b1 && m_rr.busy !== 4'hF) begin
      if (q_rr.size() == 0) begin
        chk("rr_unexpected_completion", {28'h0, m_rr.busy}, 32'hF);
      end else begin
        e = q_rr.pop_front();
        $display("rr txn ch=%0d addr=%h wr=%0b busy=%b", e.ch, s_rr.addr, e.wr, m_rr.busy);
        chk("rr_busy_channel", {28'h0, m_rr.busy}, {28'h0, ~(4'b0001 << e.ch)});
        chk("rr_s_addr", s_rr.addr, e.addr);
        if (e.wr) begin
          chk("rr_s_wen", {31'h0, s_rr.wen[0]}, 32'h1);
          chk("rr_s_wdata", s_rr.wdata, e.data);
          chk("rr_s_byte_en", {28'h0, s_rr.byte_en}, {28'h0, e.be});
        end else begin
          chk("rr_s_ren", {31'h0, s_rr.ren[0]}, 32'h1);
          chk("rr_m_rdata", m_rr.rdata, e.data);
        end
      end
    end
  end

  // Monitor for the FP arbiter.
  always @(negedge CLK) begin : mon_fp
    exp_t e;
    if (nRST === 1'b1 && m_fp.busy !== 4'hF) begin
      if (q_fp.size() == 0) begin
        chk("fp_unexpected_completion", {28'h0, m_fp.busy}, 32'hF);
      end else begin
        e = q_fp.pop_front();
        $display("fp txn ch=%0d addr=%h rdata=%h busy=%b", e.ch, s_fp.addr, m_fp.rdata, m_fp.busy);
        chk("fp_busy_channel", {28'h0, m_fp.busy}, {28'h0, ~(4'b0001 << e.ch)});
        chk("fp_s_addr", s_fp.addr, e.addr);
        chk("fp_m_rdata", m_fp.rdata, e.data);
      end
    end
  end

  // Count completions on one arbiter within a cycle budget.
  task automatic wait_done(input int d, input int n, input int budget, input string name);
    int got;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge CLK);
      if ((d == 0 ? m_rr.busy : m_fp.busy) != 4'hF) got++;
    end
    chk(name, 32'(got), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0;
    m_rr.addr = '0; m_rr.wdata = '0; m_rr.byte_en = '0; m_rr.ren = '0; m_rr.wen = '0;
    m_fp.addr = '0; m_fp.wdata = '0; m_fp.byte_en = '0; m_fp.ren = '0; m_fp.wen = '0;
    rr_rdata = 32'hDEADBEEF;

    // Reset with a request pending: ch2 read of 0x100.
    m_rr.addr[2*32 +: 32] = 32'h100;
    m_rr.ren = 4'b0100;
    push(0, 2, 32'h100, 1'b0, 32'hDEADBEEF, 4'h0);
    repeat (3) @(negedge CLK);
    chk("reset_busy", {28'h0, m_rr.busy}, 32'hF);
    chk("reset_s_ren", {31'h0, s_rr.ren[0]}, 32'h0);
    chk("reset_s_wen", {31'h0, s_rr.wen[0]}, 32'h0);
    nRST = 1'b1;
    #1;
    chk("post_release_busy", {28'h0, m_rr.busy}, 32'hF);
    chk("post_release_s_ren", {31'h0, s_rr.ren[0]}, 32'h0);

    // First arbitration edge: zero-wait read completes in the grant cycle.
    @(posedge CLK); #1;
    chk("single_s_addr", s_rr.addr, 32'h100);
    chk("single_s_ren", {31'h0, s_rr.ren[0]}, 32'h1);
    chk("single_busy", {28'h0, m_rr.busy}, 32'hB);
    chk("single_rdata", m_rr.rdata, 32'hDEADBEEF);
    @(posedge CLK); #1;
    m_rr.ren = '0;

    // Wait states: ch1 write with a 3-cycle busy slave.
    rr_wait = 3;
    m_rr.addr[1*32 +: 32]  = 32'h200;
    m_rr.wdata[1*32 +: 32] = 32'h12345678;
    m_rr.byte_en[1*4 +: 4] = 4'b0011;
    m_rr.wen = 4'b0010;
    push(0, 1, 32'h200, 1'b1, 32'h12345678, 4'b0011);
    @(posedge CLK); #1;
    for (int k = 1; k <= 4; k++) begin
      chk("wait_s_wen", {31'h0, s_rr.wen[0]}, 32'h1);
      chk("wait_s_wdata", s_rr.wdata, 32'h12345678);
      chk("wait_s_byte_en", {28'h0, s_rr.byte_en}, 32'h3);
      chk("wait_busy1", {31'h0, m_rr.busy[1]}, (k == 4) ? 32'h0 : 32'h1);
      @(posedge CLK); #1;
    end
    m_rr.wen = '0;
    rr_wait = 0;

    // Round-robin fairness from a fresh pointer: all four channels request.
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    rr_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) m_rr.addr[i*32 +: 32] = 32'h1000 + 32'(i * 4);
    m_rr.ren = 4'hF;
    push(0, 0, 32'h1000, 1'b0, 32'hCAFEF00D, 4'h0);
    push(0, 1, 32'h1004, 1'b0, 32'hCAFEF00D, 4'h0);
    push(0, 2, 32'h1008, 1'b0, 32'hCAFEF00D, 4'h0);
    push(0, 3, 32'h100C, 1'b0, 32'hCAFEF00D, 4'h0);
    push(0, 0, 32'h1000, 1'b0, 32'hCAFEF00D, 4'h0);
    wait_done(0, 5, 40, "rr_fairness_count");
    @(posedge CLK); #1;
    m_rr.ren = '0;

    // Fixed priority: ch0 and ch3 both request; ch3 only wins once ch0 withdraws.
    m_fp.addr[0*32 +: 32] = 32'h0;
    m_fp.addr[3*32 +: 32] = 32'h30;
    m_fp.ren = 4'b1001;
    push(1, 0, 32'h0, 1'b0, 32'hF00D0000, 4'h0);
    push(1, 0, 32'h0, 1'b0, 32'hF00D0000, 4'h0);
    push(1, 0, 32'h0, 1'b0, 32'hF00D0000, 4'h0);
    push(1, 3, 32'h30, 1'b0, 32'hF00D0030, 4'h0);
    wait_done(1, 3, 30, "fp_ch0_count");
    @(posedge CLK); #1;
    m_fp.ren = 4'b1000;
    wait_done(1, 1, 10, "fp_ch3_count");
    @(posedge CLK); #1;
    m_fp.ren = '0;
    repeat (2) @(posedge CLK);
    #1;

    // Abort: ch0 read withdrawn during wait states.
    rr_wait = 10;
    rr_rdata = 32'h0BADF00D;
    m_rr.addr[0*32 +: 32] = 32'h40;
    m_rr.ren = 4'b0001;
    @(posedge CLK); #1;
    chk("abort_pre_s_ren", {31'h0, s_rr.ren[0]}, 32'h1);
    chk("abort_pre_s_addr", s_rr.addr, 32'h40);
    @(posedge CLK); #1;
    m_rr.ren = '0;
    m_rr.addr[1*32 +: 32]  = 32'h80;
    m_rr.wdata[1*32 +: 32] = 32'hA5A5A5A5;
    m_rr.byte_en[1*4 +: 4] = 4'hF;
    m_rr.wen = 4'b0010;
    #1;
    chk("abort_s_ren_drop", {31'h0, s_rr.ren[0]}, 32'h0);
    chk("abort_s_wen", {31'h0, s_rr.wen[0]}, 32'h0);
    chk("abort_busy", {28'h0, m_rr.busy}, 32'hF);
    @(posedge CLK); #1;
    m_rr.ren = 4'b0001;  // ch0 re-requests; pointer now favours ch1
    @(posedge CLK); #1;
    chk("abort_next_grant_wen", {31'h0, s_rr.wen[0]}, 32'h1);
    chk("abort_next_grant_addr", s_rr.addr, 32'h80);
    chk("abort_next_busy", {28'h0, m_rr.busy}, 32'hF);

    // Asynchronous reset mid-grant drops the slave request immediately.
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("midreset_s_wen", {31'h0, s_rr.wen[0]}, 32'h0);
    chk("midreset_busy", {28'h0, m_rr.busy}, 32'hF);
    rr_wait = 0;
    @(posedge CLK); #1;
    push(0, 0, 32'h40, 1'b0, 32'h0BADF00D, 4'h0);
    push(0, 1, 32'h80, 1'b1, 32'hA5A5A5A5, 4'hF);
    nRST = 1'b1;
    wait_done(0, 1, 10, "post_reset_ch0_count");
    @(posedge CLK); #1;
    m_rr.ren = '0;
    wait_done(0, 1, 10, "post_reset_ch1_count");
    @(posedge CLK); #1;
    m_rr.wen = '0;

    repeat (3) @(negedge CLK);
    chk("rr_queue_empty", 32'(q_rr.size()), 32'h0);
    chk("fp_queue_empty", 32'(q_fp.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
